// File: rtl/div_operand_feeder_pkg.sv
// div_operand_feeder_pkg: shared operand width default and feeder FSM state encodings
package div_operand_feeder_pkg;
  localparam int N_DEF = 10;
  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] LAUNCH = 2'd1;
  localparam logic [1:0] WAIT   = 2'd2;
endpackage

// File: rtl/div_operand_feeder_fifo.sv
// op_fifo: power-of-two FIFO with extra-MSB pointers, no bypass from pop to push
module op_fifo #(
  parameter int W     = 20,
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem [DEPTH];
  logic [AW:0] wp, rp;
  logic do_push, do_pop;
  assign full    = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
  assign empty   = wp == rp;
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rp[AW-1:0]];
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wp <= '0;
      rp <= '0;
    end else begin
      wp <= wp + (AW+1)'(do_push);
      rp <= rp + (AW+1)'(do_pop);
    end
  always_ff @(posedge clk)
    if (do_push) mem[wp[AW-1:0]] <= din;
endmodule

// File: rtl/div_operand_feeder.sv
// div_operand_feeder: buffers operand pairs and issues them one at a time to the divider, dropping b==0
module div_operand_feeder
  import div_operand_feeder_pkg::*;
#(
  parameter int N     = N_DEF,
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] in_a,
  input  logic [N-1:0] in_b,
  output logic         div_start,
  output logic [N-1:0] div_a,
  output logic [N-1:0] div_b,
  input  logic         div_done,
  output logic         dz_err,
  output logic         busy
);
  logic [1:0] state;
  logic [2*N-1:0] head;
  logic full, empty, pop, b_zero;
  assign in_ready  = !full && !rst;
  assign pop       = (state == IDLE) && !empty;
  assign b_zero    = head[N-1:0] == {N{1'b0}};
  assign div_start = state == LAUNCH;
  assign busy      = !empty || (state != IDLE);
  op_fifo #(.W(2*N), .DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (in_valid && in_ready),
    .pop   (pop),
    .din   ({in_a, in_b}),
    .dout  (head),
    .full  (full),
    .empty (empty)
  );
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state  <= IDLE;
      div_a  <= '0;
      div_b  <= '0;
      dz_err <= 1'b0;
    end else begin
      dz_err <= pop && b_zero;
      state  <= pop ? (b_zero ? IDLE : LAUNCH) :
                (state == LAUNCH) ? WAIT :
                (state == WAIT && div_done) ? IDLE : state;
      if (pop && !b_zero) begin
        div_a <= head[2*N-1:N];
        div_b <= head[N-1:0];
      end
    end
endmodule

// File: tb/tb_div_operand_feeder.sv
// tb_div_operand_feeder: table-driven single-pair vectors plus directed multi-cycle sequences
module tb_div_operand_feeder;
  localparam int N = 10;
  logic clk = 1'b0, rst = 1'b1, in_valid = 1'b0, div_done = 1'b0;
  logic [N-1:0] in_a = '0, in_b = '0;
  logic in_ready, div_start, dz_err, busy;
  logic [N-1:0] div_a, div_b;
  int checks = 0, errors = 0;

  typedef struct {
    logic [N-1:0] a;
    logic [N-1:0] b;
  } vec_t;
  vec_t vecs [6];

  div_operand_feeder #(.N(N), .DEPTH(2)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .div_start(div_start), .div_a(div_a),
    .div_b(div_b), .div_done(div_done), .dz_err(dz_err), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  // from IDLE/empty at posedge+1: push one pair, follow it to issue or drop
  task automatic run_vec(input vec_t v);
    logic nz;
    nz = v.b != '0;
    in_valid = 1'b1; in_a = v.a; in_b = v.b;
    settle(); chk("vec_in_ready", in_ready, 1);
    tick(); in_valid = 1'b0;
    settle(); chk("vec_c1_start", div_start, 0); chk("vec_c1_busy", busy, 1);
    tick();
    settle();
    chk("vec_c2_start", div_start, nz); chk("vec_c2_dz", dz_err, !nz); chk("vec_c2_busy", busy, nz);
    if (nz) begin
      chk("vec_div_a", div_a, v.a); chk("vec_div_b", div_b, v.b);
      tick(); settle();
      chk("vec_wait_start", div_start, 0); chk("vec_wait_a", div_a, v.a); chk("vec_wait_b", div_b, v.b);
      div_done = 1'b1;
      tick(); div_done = 1'b0;
      settle(); chk("vec_done_busy", busy, 0);
    end else begin
      tick(); settle(); chk("vec_dz_clear", dz_err, 0);
    end
    tick();
  endtask

  // wait (bounded) for the next start, check operands, then complete it
  task automatic expect_issue(input logic [N-1:0] a, input logic [N-1:0] b);
    bit found = 1'b0;
    for (int i = 0; i < 12 && !found; i++) begin
      settle();
      if (div_start) found = 1'b1;
      else tick();
    end
    chk("issue_seen", found, 1);
    chk("issue_a", div_a, a);
    chk("issue_b", div_b, b);
    tick(); div_done = 1'b1;
    tick(); div_done = 1'b0;
  endtask

  task automatic push3();
    in_valid = 1'b1; in_a = 10'd11; in_b = 10'd1;
    tick(); in_a = 10'd22; in_b = 10'd2;
    tick(); in_a = 10'd33; in_b = 10'd3;
    tick();
  endtask

  initial begin
    vecs[0] = '{10'd600, 10'd3};
    vecs[1] = '{10'd5, 10'd0};
    vecs[2] = '{10'd1023, 10'd1023};
    vecs[3] = '{10'd0, 10'd1};
    vecs[4] = '{10'd1, 10'd1023};
    vecs[5] = '{10'd512, 10'd0};
    #2;
    chk("rst_in_ready", in_ready, 0); chk("rst_start", div_start, 0);
    chk("rst_div_a", div_a, 0); chk("rst_div_b", div_b, 0);
    chk("rst_dz", dz_err, 0); chk("rst_busy", busy, 0);
    tick(); tick(); rst = 1'b0;
    settle(); chk("post_rst_in_ready", in_ready, 1);
    tick();

    for (int i = 0; i < 6; i++) run_vec(vecs[i]);

    // back-to-back zero divisors
    in_valid = 1'b1; in_a = 10'd5; in_b = 10'd0;
    tick(); in_a = 10'd7;
    tick(); in_valid = 1'b0;
    settle(); chk("dz2_first", dz_err, 1); chk("dz2_start_a", div_start, 0);
    tick(); settle(); chk("dz2_second", dz_err, 1); chk("dz2_busy", busy, 0); chk("dz2_start_b", div_start, 0);
    tick(); settle(); chk("dz2_clear", dz_err, 0); chk("dz2_start_c", div_start, 0);
    tick();

    // fill while WAIT, pop and in_valid in the same cycle while full
    push3();
    in_a = 10'd44; in_b = 10'd4;
    settle(); chk("full_in_ready", in_ready, 0);
    for (int i = 0; i < 3; i++) begin
      tick(); settle(); chk("full_hold_ready", in_ready, 0); chk("full_hold_busy", busy, 1);
    end
    div_done = 1'b1;
    tick(); div_done = 1'b0;
    settle(); chk("pop_cycle_no_push", in_ready, 0);
    tick(); settle();
    chk("after_pop_ready", in_ready, 1); chk("p2_start", div_start, 1);
    chk("p2_a", div_a, 22); chk("p2_b", div_b, 2);
    tick(); in_valid = 1'b0; div_done = 1'b1;
    tick(); div_done = 1'b0;
    expect_issue(10'd33, 10'd3);
    expect_issue(10'd44, 10'd4);
    settle(); chk("order_drained_busy", busy, 0);
    tick();

    // done in IDLE and LAUNCH is ignored
    in_valid = 1'b1; in_a = 10'd100; in_b = 10'd7; div_done = 1'b1;
    tick(); in_valid = 1'b0;
    tick(); settle(); chk("ign_launch_start", div_start, 1); chk("ign_a", div_a, 100);
    tick(); div_done = 1'b0;
    for (int i = 0; i < 4; i++) begin
      settle(); chk("ign_still_busy", busy, 1); chk("ign_no_restart", div_start, 0);
      tick();
    end
    settle(); div_done = 1'b1;
    tick(); div_done = 1'b0;
    settle(); chk("ign_done_busy", busy, 0);
    tick();

    // reset in WAIT with two queued
    push3();
    in_valid = 1'b0;
    tick(); settle(); chk("rst5_full", in_ready, 0); chk("rst5_busy_pre", busy, 1);
    rst = 1'b1; #1;
    chk("rst5_in_ready", in_ready, 0); chk("rst5_start", div_start, 0);
    chk("rst5_a", div_a, 0); chk("rst5_b", div_b, 0);
    chk("rst5_dz", dz_err, 0); chk("rst5_busy", busy, 0);
    tick(); tick(); rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      settle(); chk("rst5_idle_start", div_start, 0); chk("rst5_idle_busy", busy, 0);
      chk("rst5_idle_ready", in_ready, 1);
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
